// File: rtl/fms_pkg.sv
// ============================================================================
// Module   : fms_pkg
// Purpose  : Shared state encoding and default 720p timing constants for the
//            frame memory scheduler and the video timing generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fms_state_t;

  localparam int c_active_h_pixels = 1280;
  localparam int c_total_pixels    = 1650;
  localparam int c_active_lines    = 720;
  localparam int c_total_lines     = 750;
  localparam int c_line_words      = 80;

endpackage

`default_nettype wire

// File: rtl/fms_rd_pipe.sv
// ============================================================================
// Module   : fms_rd_pipe
// Purpose  : DEPTH-deep {valid, word index} shift register tracking reads in
//            flight to the frame memory, with a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fms_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 7
) (
  input  logic             pixel_clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pend
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_idx [DEPTH];

  always_ff @(posedge pixel_clk) begin
    if (rst || flush) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
    end else begin
      r_valid[0] <= in_valid;
      r_idx[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_idx   = r_idx[DEPTH-1];

  // pend: a read that has not yet reached the output stage
  generate
    if (DEPTH > 1) begin : g_deep
      assign pend = in_valid | (|r_valid[DEPTH-2:0]);
    end else begin : g_single
      assign pend = in_valid;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/frame_mem_scheduler.sv
// ============================================================================
// Module   : frame_mem_scheduler
// Purpose  : Arbitrates the single-port frame memory between the display line
//            prefetcher (ping-pong line buffer) and the renderer writer.
//            Optional macro FMS_RENDER_INTERLEAVE_EN grants every 4th FETCH
//            cycle to the renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_mem_scheduler
  import fms_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = c_active_h_pixels,
  parameter int TOTAL_PIXELS    = c_total_pixels,
  parameter int ACTIVE_LINES    = c_active_lines,
  parameter int TOTAL_LINES     = c_total_lines,
  parameter int LINE_WORDS      = c_line_words,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 64,
  parameter int READ_LATENCY    = 2
) (
  input  logic                            pixel_clk,
  input  logic                            rst,
  input  logic [$clog2(TOTAL_PIXELS)-1:0] h_count,
  input  logic [$clog2(TOTAL_LINES)-1:0]  v_count,
  input  logic                            wr_req,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_ack,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            lb_we,
  output logic                            lb_bank,
  output logic [$clog2(LINE_WORDS)-1:0]   lb_addr,
  output logic [DATA_WIDTH-1:0]           lb_data,
  output logic                            fetch_busy,
  output logic                            underrun
);

  localparam int c_hw = $clog2(TOTAL_PIXELS);
  localparam int c_vw = $clog2(TOTAL_LINES);
  localparam int c_lw = $clog2(LINE_WORDS);

  localparam logic [c_hw-1:0]       c_trig_h     = c_hw'(ACTIVE_H_PIXELS);
  localparam logic [c_hw-1:0]       c_dead_h     = c_hw'(TOTAL_PIXELS - 1);
  localparam logic [c_vw-1:0]       c_last_fetch = c_vw'(ACTIVE_LINES - 1);
  localparam logic [c_vw-1:0]       c_last_line  = c_vw'(TOTAL_LINES - 1);
  localparam logic [c_lw-1:0]       c_last_word  = c_lw'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_line_step  = ADDR_WIDTH'(LINE_WORDS);

  fms_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [c_lw-1:0]       r_word;
  logic                  r_bank;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rd_valid;
  logic [c_lw-1:0]       r_rd_word;
  logic                  r_underrun;

  logic                  w_wrap;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_rnd_slot;
  logic                  w_port_free;
  logic                  w_fetch_rd;
  logic                  w_rd_issue;
  logic [ADDR_WIDTH-1:0] w_new_base;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [c_lw-1:0]       w_rd_idx;
  logic                  w_pipe_pend;

  // Line 0 follows the last blanking line; every other target is v_count+1.
  assign w_wrap  = (v_count == c_last_line);
  assign w_start = (r_state == IDLE) && (h_count == c_trig_h) &&
                   ((v_count < c_last_fetch) || w_wrap);
  assign w_abort = (h_count == c_dead_h) && (r_state != IDLE);

`ifdef FMS_RENDER_INTERLEAVE_EN
  logic [1:0] r_slot;
  assign w_rnd_slot = (r_state == FETCH) && (r_slot == 2'd3);
`else
  assign w_rnd_slot = 1'b0;
`endif

  assign w_port_free = (r_state == IDLE) || (r_state == DRAIN) || w_rnd_slot;
  assign wr_ack      = wr_req && w_port_free && !w_start;

  // The trigger cycle itself issues word 0 so it lands on mem_* one cycle later.
  assign w_fetch_rd = (r_state == FETCH) && !w_abort && !(w_rnd_slot && wr_req);
  assign w_rd_issue = w_start || w_fetch_rd;
  assign w_new_base = w_wrap ? '0 : r_base + c_line_step;
  assign w_rd_addr  = w_start ? w_new_base : r_base + ADDR_WIDTH'(r_word);
  assign w_rd_idx   = w_start ? '0 : r_word;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_word      <= '0;
      r_bank      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_word   <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_word  <= w_rd_idx;

      if (w_rd_issue) begin
        r_mem_en   <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= w_rd_addr;
      end else if (wr_ack) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= wr_addr;
        r_mem_wdata <= wr_data;
      end else begin
        r_mem_en <= 1'b0;
        r_mem_we <= 1'b0;
      end

      if (w_abort) r_underrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= FETCH;
            r_base  <= w_new_base;
            r_word  <= c_lw'(1);
            r_bank  <= w_wrap ? 1'b0 : ~v_count[0];
          end
        end
        FETCH: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (w_fetch_rd) begin
            r_word <= r_word + 1'b1;
            if (r_word == c_last_word) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_abort || !w_pipe_pend) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FMS_RENDER_INTERLEAVE_EN
  // Slot 0 is the trigger cycle, so the first renderer slot is the 4th cycle.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_slot <= 2'd0;
    end else if (w_start) begin
      r_slot <= 2'd1;
    end else if (r_state == FETCH) begin
      r_slot <= r_slot + 2'd1;
    end
  end
`endif

  fms_rd_pipe #(
    .DEPTH (READ_LATENCY),
    .IDX_W (c_lw)
  ) u_rd_pipe (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .flush     (w_abort),
    .in_valid  (r_rd_valid),
    .in_idx    (r_rd_word),
    .out_valid (lb_we),
    .out_idx   (lb_addr),
    .pend      (w_pipe_pend)
  );

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign lb_bank    = r_bank;
  assign lb_data    = mem_rdata;
  assign fetch_busy = (r_state != IDLE);
  assign underrun   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_frame_mem_scheduler.sv
// ============================================================================
// Module   : tb_frame_mem_scheduler
// Purpose  : Directed scoreboard bench for frame_mem_scheduler (60-cycle
//            blanking build, TOTAL_PIXELS=1340).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_mem_scheduler;

  localparam int c_tp = 1340;
`ifdef FMS_RENDER_INTERLEAVE_EN
  localparam int c_first_ack = 3;
`else
  localparam int c_first_ack = 80;
`endif

  logic        pixel_clk = 1'b0;
  logic        rst;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        lb_we;
  logic        lb_bank;
  logic [6:0]  lb_addr;
  logic [63:0] lb_data;
  logic        fetch_busy;
  logic        underrun;

  frame_mem_scheduler #(
    .TOTAL_PIXELS (c_tp)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .h_count    (h_count),
    .v_count    (v_count),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .lb_we      (lb_we),
    .lb_bank    (lb_bank),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC3A5};
  endfunction

  // Frame memory model: read data two cycles after the strobe
  logic [15:0] r_p0, r_p1;
  always @(posedge pixel_clk) begin
    r_p1 <= r_p0;
    r_p0 <= mem_addr;
  end
  assign mem_rdata = mem_word(r_p1);

  typedef struct packed {logic [15:0] addr; logic [63:0] data;} wr_exp_t;
  typedef struct packed {logic bank; logic [6:0] idx; logic [63:0] data;} lb_exp_t;

  wr_exp_t     exp_wr[$];
  logic [15:0] exp_rd[$];
  lb_exp_t     exp_lb[$];
  int          checks = 0;
  int          fails  = 0;
  bit          sb_en  = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic push_line(input logic [15:0] base, input logic bank);
    for (int i = 0; i < 80; i++) begin
      exp_rd.push_back(base + 16'(i));
      exp_lb.push_back({bank, 7'(i), mem_word(base + 16'(i))});
    end
  endtask

  task automatic run_fetch(input logic [9:0] v, input logic [15:0] base,
                           input logic bank, output int lat);
    push_line(base, bank);
    h_count = 11'd1280;
    v_count = v;
    step();
    h_count = 11'd100;
    lat = 1;
    @(negedge pixel_clk);
    while (fetch_busy && lat < 400) begin
      step();
      lat++;
      @(negedge pixel_clk);
    end
  endtask

  wr_exp_t     m_wr;
  lb_exp_t     m_lb;
  logic [15:0] m_rd;

  always @(negedge pixel_clk) begin
    if (sb_en && !rst) begin
      if (mem_en && mem_we) begin
        check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          m_wr = exp_wr.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(m_wr.addr));
          check("wr_data", mem_wdata, m_wr.data);
        end
      end
      if (mem_en && !mem_we) begin
        check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) begin
          m_rd = exp_rd.pop_front();
          check("rd_addr", 64'(mem_addr), 64'(m_rd));
        end
      end
      if (lb_we) begin
        check("lb_expected", 64'(exp_lb.size() != 0), 64'd1);
        if (exp_lb.size() != 0) begin
          m_lb = exp_lb.pop_front();
          check("lb_bank", 64'(lb_bank), 64'(m_lb.bank));
          check("lb_addr", 64'(lb_addr), 64'(m_lb.idx));
          check("lb_data", lb_data, m_lb.data);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_en"},     64'(mem_en),     64'd0);
    check({tag, "_mem_we"},     64'(mem_we),     64'd0);
    check({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
    check({tag, "_mem_wdata"},  mem_wdata,       64'd0);
    check({tag, "_lb_we"},      64'(lb_we),      64'd0);
    check({tag, "_lb_bank"},    64'(lb_bank),    64'd0);
    check({tag, "_lb_addr"},    64'(lb_addr),    64'd0);
    check({tag, "_fetch_busy"}, 64'(fetch_busy), 64'd0);
    check({tag, "_underrun"},   64'(underrun),   64'd0);
    check({tag, "_wr_ack"},     64'(wr_ack),     64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, first, cyc, lbw, post;
    logic [6:0] last;

    rst = 1'b1; h_count = '0; v_count = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) step();
    @(negedge pixel_clk);
    check_idle_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // Renderer writes while idle: acked same cycle, one per cycle
    for (int i = 0; i < 4; i++) begin
      wr_addr = 16'h1234 + 16'(i);
      wr_data = 64'hAA + 64'(i);
      wr_req  = 1'b1;
      @(negedge pixel_clk);
      check("wr_ack_idle", 64'(wr_ack), 64'd1);
      exp_wr.push_back({wr_addr, wr_data});
      step();
    end
    wr_req = 1'b0;
    repeat (2) step();

    // Last active line has no following line to fetch
    h_count = 11'd1280; v_count = 10'd719;
    step();
    h_count = 11'd100;
    @(negedge pixel_clk);
    check("no_fetch_busy", 64'(fetch_busy), 64'd0);
    check("no_fetch_mem",  64'(mem_en),     64'd0);
    step();

    run_fetch(10'd749, 16'd0, 1'b0, lat);
    check("lat_line0", 64'(lat), 64'd83);
    for (int i = 0; i < 5; i++) begin
      run_fetch(10'(i), 16'(80 * (i + 1)), 1'((i + 1) & 1), lat);
      check("lat_line", 64'(lat), 64'd83);
    end

    // wr_req held across a fetch of line 6 (base 480, bank 0)
    step();
    push_line(16'd480, 1'b0);
    wr_addr = 16'h0777; wr_data = 64'h0123_4567_89AB_CDEF; wr_req = 1'b1;
    h_count = 11'd1280; v_count = 10'd5;
    first = -1; cyc = 0;
    while (cyc < 400) begin
      @(negedge pixel_clk);
      if (first >= 0 && !fetch_busy) break;
      if (wr_ack) begin
        exp_wr.push_back({wr_addr, wr_data});
        if (first < 0) first = cyc;
      end
      step();
      h_count = 11'd100;
      cyc++;
    end
    wr_req = 1'b0;
    check("hold_first_ack", 64'(first), 64'(c_first_ack));
    check("hold_done", 64'(cyc < 400), 64'd1);
    repeat (4) step();
    check("q_rd_empty", 64'(exp_rd.size()), 64'd0);
    check("q_lb_empty", 64'(exp_lb.size()), 64'd0);
    check("q_wr_empty", 64'(exp_wr.size()), 64'd0);

    // Deadline miss: only 60 blanking cycles for an 83-cycle fetch
    sb_en = 1'b0;
    lbw = 0; last = '0;
    h_count = 11'd1280; v_count = 10'd6;
    for (int k = 0; k < 60; k++) begin
      @(negedge pixel_clk);
      if (lb_we) begin
        lbw++;
        last = lb_addr;
      end
      step();
      h_count = 11'(1281 + k);
    end
    h_count = 11'd100;
    @(negedge pixel_clk);
    check("urun_set",      64'(underrun),   64'd1);
    check("urun_idle",     64'(fetch_busy), 64'd0);
    check("urun_no_rd",    64'(mem_en),     64'd0);
    check("urun_no_lb",    64'(lb_we),      64'd0);
    check("urun_lb_count", 64'(lbw),        64'd57);
    check("urun_lb_last",  64'(last),       64'd56);
    post = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      @(negedge pixel_clk);
      if (lb_we) post++;
    end
    check("urun_post_lb", 64'(post),     64'd0);
    check("urun_sticky",  64'(underrun), 64'd1);

    // Reset in the middle of a fetch
    step();
    h_count = 11'd1280; v_count = 10'd7;
    step();
    h_count = 11'd100;
    repeat (10) step();
    rst = 1'b1;
    step();
    @(negedge pixel_clk);
    check_idle_outputs("midrst");
    step();
    rst = 1'b0;
    repeat (5) step();

    // Fetching resumes from a reset base
    sb_en = 1'b1;
    run_fetch(10'd749, 16'd0, 1'b0, lat);
    check("lat_after_rst", 64'(lat), 64'd83);
    repeat (4) step();
    check("q_rd_empty_end", 64'(exp_rd.size()), 64'd0);
    check("q_lb_empty_end", 64'(exp_lb.size()), 64'd0);
    check("q_wr_empty_end", 64'(exp_wr.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
